// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential instruction prefetch FIFO between fetch stage and variable-latency memory
// Ports: clk/reset (async, active-high); pc_f/fetch_en from the pipeline;
//   instr_f/instr_valid back to fetch; mem_req/mem_addr/mem_ack/mem_rdata to instruction memory.
// Optional: define IFB_BYPASS_EN to forward returning data in the same cycle when the buffer is empty.
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic        fetch_en,
  output logic [31:0] instr_f,
  output logic        instr_valid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_head_pc;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_mem_addr;

  logic [31:0] w_pc;
  logic        w_redirect;
  logic        w_hit;
  logic        w_pop;
  logic        w_ack_ok;
  logic        w_byp;
  logic        w_consume;
  logic        w_push;
  logic        w_issue;

  assign w_pc       = pc_f & 32'hFFFF_FFFC;
  assign w_redirect = w_pc != r_head_pc;
  assign w_hit      = (r_count != '0) && !w_redirect;
  assign w_pop      = w_hit && fetch_en;
  // an ack only delivers usable data in WAIT with the stream unbroken
  assign w_ack_ok   = (r_state == WAIT) && mem_ack && !w_redirect;
`ifdef IFB_BYPASS_EN
  assign w_byp      = w_ack_ok && (r_count == '0) && (r_mem_addr == w_pc);
`else
  assign w_byp      = 1'b0;
`endif
  assign w_consume  = w_byp && fetch_en;
  assign w_push     = w_ack_ok && !w_consume;
  // a redirect flushes the FIFO, so issuing is always allowed then
  assign w_issue    = (r_state == IDLE) && (w_redirect || (r_count < FULL) || w_pop);

  assign instr_valid = w_hit || w_byp;
  assign instr_f     = w_hit ? r_fifo[r_rd_ptr] : w_byp ? mem_rdata : 32'h0;
  assign mem_req     = r_state != IDLE;
  assign mem_addr    = r_mem_addr;

  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (w_issue ? WAIT : IDLE) :
                  (r_state == WAIT) ? (mem_ack ? IDLE : w_redirect ? DROP : WAIT) :
                  (mem_ack ? IDLE : DROP);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_pc    <= RESET_PC;
      r_fetch_addr <= RESET_PC;
      r_mem_addr   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_mem_addr <= w_redirect ? w_pc : r_fetch_addr;
      if (w_redirect) begin
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
        r_head_pc    <= w_pc;
        r_fetch_addr <= w_pc;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_pop || w_consume) r_head_pc <= r_head_pc + 32'd4;
        if (w_ack_ok) r_fetch_addr <= r_fetch_addr + 32'd4;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed self-checking bench for ifetch_buffer
module tb_ifetch_buffer;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
`ifdef IFB_BYPASS_EN
  localparam int FIRST_VALID = 1;
`else
  localparam int FIRST_VALID = 2;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic        fetch_en;
  logic [31:0] instr_f;
  logic        instr_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int age = 0;
  bit was_req = 0;

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .fetch_en(fetch_en),
    .instr_f(instr_f), .instr_valid(instr_valid),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: acks once a request has been held for lat earlier cycles; rdata = addr ^ MASK
  always begin
    @(posedge clk);
    #2;
    age = mem_req ? (was_req ? age + 1 : 0) : 0;
    was_req = mem_req;
    mem_ack = mem_req && (age >= lat);
    mem_rdata = mem_addr ^ MASK;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; pc_f = 32'h0; fetch_en = 1'b0; lat = 0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (instr_f !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr_f); end
  endtask

  task automatic test_stream;
    int first = -1;
    int last = -1;
    int nvalid = 0;
    bit v;
    pc_f = 32'h0; fetch_en = 1'b1; lat = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v = instr_valid;
      if (v) begin
        nvalid++;
        if (first < 0) first = i;
        total++; if (instr_f !== (pc_f ^ MASK)) begin bad++; $display("FAIL stream_data pc=%h got=%h exp=%h", pc_f, instr_f, pc_f ^ MASK); end
        if (last >= 0) begin
          total++; if (i - last > 2) begin bad++; $display("FAIL stream_gap cycle=%0d gap=%0d exp<=2", i, i - last); end
        end
        last = i;
      end
      tick();
      if (v) pc_f = pc_f + 32'd4;
    end
    total++; if (first != FIRST_VALID) begin bad++; $display("FAIL first_valid got=%0d exp=%0d", first, FIRST_VALID); end
    total++; if (nvalid < 6) begin bad++; $display("FAIL stream_count got=%0d exp>=6", nvalid); end
  endtask

  task automatic test_full;
    int pushes = 0;
    pc_f = 32'h0; fetch_en = 1'b0; lat = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack) pushes++;
      tick();
    end
    @(negedge clk);
    total++; if (pushes != 4) begin bad++; $display("FAIL full_pushes got=%0d exp=4", pushes); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req got=%b exp=0", mem_req); end
    total++; if (instr_valid !== 1'b1 || instr_f !== MASK) begin bad++; $display("FAIL full_head got=%b/%h exp=1/%h", instr_valid, instr_f, MASK); end
    tick();
    fetch_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instr_f !== ((32'(k) * 32'd4) ^ MASK)) begin
        bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, instr_valid, instr_f, (32'(k) * 32'd4) ^ MASK);
      end
      tick();
      pc_f = pc_f + 32'd4;
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_redirect_drop;
    logic [31:0] new_addr = 32'hDEAD_BEEF;
    logic [31:0] first_data = 32'hDEAD_BEEF;
    bit seen_new = 0;
    bit got = 0;
    pc_f = 32'h0; fetch_en = 1'b0; lat = 3;
    do_reset();
    tick();
    pc_f = 32'h100;
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL drop_hold got=%b/%h exp=1/0", mem_req, mem_addr); end
      end
      if (mem_req && mem_addr != 32'h0 && !seen_new) begin seen_new = 1; new_addr = mem_addr; end
      if (instr_valid && !got) begin got = 1; first_data = instr_f; end
      tick();
    end
    total++; if (new_addr !== 32'h100) begin bad++; $display("FAIL drop_newaddr got=%h exp=00000100", new_addr); end
    total++; if (!got || first_data !== (32'h100 ^ MASK)) begin bad++; $display("FAIL drop_data got=%h exp=%h", first_data, 32'h100 ^ MASK); end
    lat = 0;
  endtask

  task automatic test_redirect_ack;
    pc_f = 32'h0; fetch_en = 1'b0; lat = 0;
    do_reset();
    tick();
    pc_f = 32'h200;
    #2;
    total++; if (mem_req !== 1'b1 || mem_ack !== 1'b1) begin bad++; $display("FAIL rack_pre got=%b/%b exp=1/1", mem_req, mem_ack); end
    tick();
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rack_valid got=%b exp=0", instr_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rack_idle got=%b exp=0", mem_req); end
    tick();
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL rack_addr got=%b/%h exp=1/00000200", mem_req, mem_addr); end
    tick();
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_f !== (32'h200 ^ MASK)) begin bad++; $display("FAIL rack_data got=%b/%h exp=1/%h", instr_valid, instr_f, 32'h200 ^ MASK); end
  endtask

  task automatic test_wrap;
    logic [31:0] addrs [3];
    logic [31:0] exp_a [3];
    int n = 0;
    bit prev = 0;
    bit v;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0;
    pc_f = 32'h0; fetch_en = 1'b0; lat = 0;
    do_reset();
    pc_f = 32'hFFFF_FFF8; fetch_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_req && !prev && n < 3) begin addrs[n] = mem_addr; n++; end
      prev = mem_req;
      v = instr_valid;
      if (v) begin
        total++; if (instr_f !== (pc_f ^ MASK)) begin bad++; $display("FAIL wrap_data pc=%h got=%h exp=%h", pc_f, instr_f, pc_f ^ MASK); end
      end
      tick();
      if (v) pc_f = pc_f + 32'd4;
    end
    total++; if (n != 3) begin bad++; $display("FAIL wrap_nreq got=%0d exp=3", n); end
    for (int k = 0; k < n; k++) begin
      total++; if (addrs[k] !== exp_a[k]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, addrs[k], exp_a[k]); end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    pc_f = 32'h0; fetch_en = 1'b0; lat = 0;
    do_reset();
    tick();
    tick();
    lat = 3;
    tick();
    #2;
    total++; if (mem_req !== 1'b1 || instr_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b/%b exp=1/1", mem_req, instr_valid); end
    reset = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b exp=0", mem_req); end
    total++; if (instr_valid !== 1'b0 || instr_f !== 32'h0) begin bad++; $display("FAIL rmid_valid got=%b/%h exp=0/0", instr_valid, instr_f); end
    lat = 0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1;
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_restart got=%h exp=0", mem_addr); end
      end
      tick();
    end
    total++; if (!found) begin bad++; $display("FAIL rmid_timeout got=no_req exp=req"); end
  endtask

  initial begin
    reset = 1'b1; pc_f = 32'h0; fetch_en = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
